// File: rtl/fan_ctrl_multi_pkg.sv
`timescale 1ns/1ps
// Shared defaults, ramp direction type and duty helpers for the multi-channel fan controller.
package fan_ctrl_multi_pkg;
    localparam int N_FAN_DEF     = 3;
    localparam int PERIOD_DEF    = 222;
    localparam int MIN_DUTY_DEF  = 60;
    localparam int TEMP_LO_DEF   = 40;
    localparam int SLOPE_DEF     = 6;
    localparam int RAMP_DIV_DEF  = 7812;
    localparam int TEMP_TMO_DEF  = 7812500;
    localparam int TACH_WIN_DEF  = 3906250;
    localparam int TACH_DEB_DEF  = 8;
    localparam int TACH_MIN_DEF  = 10;
    localparam int FAIL_WINS_DEF = 2;

    typedef enum logic [1:0] {RAMP_HOLD, RAMP_UP, RAMP_DOWN} ramp_dir_e;

    function automatic logic [7:0] sat_duty(input logic [15:0] raw, input logic [15:0] period);
        return (raw > period) ? period[7:0] : raw[7:0];
    endfunction

    function automatic ramp_dir_e ramp_dir(input logic [7:0] cur, input logic [7:0] tgt);
        ramp_dir_e dir;
        dir = RAMP_HOLD;
        if (cur < tgt)
            dir = RAMP_UP;
        else if (cur > tgt)
            dir = RAMP_DOWN;
        return dir;
    endfunction
endpackage

// File: rtl/fan_ctrl_multi_if.sv
`timescale 1ns/1ps
// Control/status bundle between the fan controller and its host logic.
interface fan_ctrl_multi_if #(parameter int N_FAN = 3);
    logic                 enable;
    logic                 temp_valid;
    logic [7:0]           temp_data;
    logic                 manual_en;
    logic [8*N_FAN-1:0]   manual_duty;
    logic [N_FAN-1:0]     tach_in;
    logic [N_FAN-1:0]     pwm_out;
    logic [8*N_FAN-1:0]   duty_cur;
    logic [16*N_FAN-1:0]  tach_count;
    logic [N_FAN-1:0]     fan_fail;
    logic                 failsafe;

    modport master (
        output enable, temp_valid, temp_data, manual_en, manual_duty, tach_in,
        input  pwm_out, duty_cur, tach_count, fan_fail, failsafe
    );

    modport slave (
        input  enable, temp_valid, temp_data, manual_en, manual_duty, tach_in,
        output pwm_out, duty_cur, tach_count, fan_fail, failsafe
    );
endinterface

// File: rtl/fan_ctrl_multi_tach_meter.sv
`timescale 1ns/1ps
// One tach channel: synchroniser, debounce, rising-edge count per window and stall flag.
module fan_tach_meter
    import fan_ctrl_multi_pkg::*;
#(
    parameter int TACH_DEB  = TACH_DEB_DEF,
    parameter int TACH_MIN  = TACH_MIN_DEF,
    parameter int FAIL_WINS = FAIL_WINS_DEF
) (
    input  logic        clk0,
    input  logic        rstn,
    input  logic        enable,
    input  logic        tach_in,
    input  logic        win_end,
    input  logic        duty_ok,
    output logic [15:0] tach_count,
    output logic        fan_fail
);
    localparam int DEB_W = $clog2(TACH_DEB + 1);
    localparam int FW_W  = $clog2(FAIL_WINS + 1);

    logic             sync1_reg, sync2_reg, deb_level_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic [15:0]      edge_cnt_reg;
    logic [FW_W-1:0]  low_cnt_reg;
    logic             deb_accept, rise;

    // The new level is taken on the TACH_DEB-th consecutive sample that differs from the old one
    assign deb_accept = (sync2_reg != deb_level_reg) && (deb_cnt_reg == DEB_W'(TACH_DEB - 1));
    assign rise       = deb_accept && sync2_reg;

    always_ff @(posedge clk0 or negedge rstn) begin
        if (!rstn) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            deb_level_reg <= 1'b0;
            deb_cnt_reg   <= '0;
            edge_cnt_reg  <= '0;
            low_cnt_reg   <= '0;
            tach_count    <= '0;
            fan_fail      <= 1'b0;
        end else begin
            sync1_reg <= tach_in;
            sync2_reg <= sync1_reg;
            if (sync2_reg == deb_level_reg || deb_accept)
                deb_cnt_reg <= '0;
            else
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            if (deb_accept)
                deb_level_reg <= sync2_reg;

            if (!enable) begin
                edge_cnt_reg <= '0;
                low_cnt_reg  <= '0;
                fan_fail     <= 1'b0;
            end else if (win_end) begin
                tach_count   <= edge_cnt_reg;
                edge_cnt_reg <= {15'd0, rise};
                if (edge_cnt_reg >= 16'(TACH_MIN)) begin
                    low_cnt_reg <= '0;
                    fan_fail    <= 1'b0;
                end else if (duty_ok) begin
                    if (low_cnt_reg != FW_W'(FAIL_WINS))
                        low_cnt_reg <= low_cnt_reg + 1'b1;
                    if (low_cnt_reg >= FW_W'(FAIL_WINS - 1))
                        fan_fail <= 1'b1;
                end
            end else if (rise && edge_cnt_reg != 16'hFFFF) begin
                edge_cnt_reg <= edge_cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fan_ctrl_multi.sv
`timescale 1ns/1ps
// N-channel fan controller: temperature curve, slew-limited duty, PWM, tach monitoring, failsafe.
module fan_ctrl_multi
    import fan_ctrl_multi_pkg::*;
#(
    parameter int N_FAN     = N_FAN_DEF,
    parameter int PERIOD    = PERIOD_DEF,
    parameter int MIN_DUTY  = MIN_DUTY_DEF,
    parameter int TEMP_LO   = TEMP_LO_DEF,
    parameter int SLOPE     = SLOPE_DEF,
    parameter int RAMP_DIV  = RAMP_DIV_DEF,
    parameter int TEMP_TMO  = TEMP_TMO_DEF,
    parameter int TACH_WIN  = TACH_WIN_DEF,
    parameter int TACH_DEB  = TACH_DEB_DEF,
    parameter int TACH_MIN  = TACH_MIN_DEF,
    parameter int FAIL_WINS = FAIL_WINS_DEF
) (
    input logic             clk0,
    input logic             rstn,
    fan_ctrl_multi_if.slave bus
);
    localparam int          TMO_W    = $clog2(TEMP_TMO + 1);
    localparam int          RDIV_W   = $clog2(RAMP_DIV + 1);
    localparam int          WIN_W    = $clog2(TACH_WIN + 1);
    localparam logic [15:0] PERIOD16 = 16'(PERIOD);
    localparam logic [7:0]  PERIOD8  = 8'(PERIOD);
    localparam logic [7:0]  PWM_LAST = 8'(PERIOD - 1);

    logic [7:0]        temp_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [RDIV_W-1:0] rdiv_cnt_reg;
    logic [7:0]        pwm_cnt_reg;
    logic [WIN_W-1:0]  win_cnt_reg;
    logic              failsafe_reg;
    logic              tmo_hit, ramp_tick, win_end, pwm_wrap;
    logic [15:0]       curve_raw;
    logic [7:0]        curve_duty;

    assign tmo_hit      = (tmo_cnt_reg == TMO_W'(TEMP_TMO));
    assign ramp_tick    = bus.enable && (rdiv_cnt_reg == RDIV_W'(RAMP_DIV - 1));
    assign win_end      = bus.enable && (win_cnt_reg == WIN_W'(TACH_WIN - 1));
    assign pwm_wrap     = (pwm_cnt_reg == PWM_LAST);
    assign bus.failsafe = failsafe_reg;

    always_ff @(posedge clk0 or negedge rstn) begin
        if (!rstn) begin
            temp_reg     <= '0;
            tmo_cnt_reg  <= '0;
            rdiv_cnt_reg <= '0;
            pwm_cnt_reg  <= '0;
            win_cnt_reg  <= '0;
            failsafe_reg <= 1'b0;
        end else begin
            if (bus.temp_valid)
                temp_reg <= bus.temp_data;
            // A fresh reading wins over a timeout expiring in the same cycle
            if (!bus.enable || bus.manual_en || bus.temp_valid)
                tmo_cnt_reg <= '0;
            else if (!tmo_hit)
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            rdiv_cnt_reg <= (!bus.enable || ramp_tick) ? '0 : rdiv_cnt_reg + 1'b1;
            pwm_cnt_reg  <= (!bus.enable || pwm_wrap)  ? '0 : pwm_cnt_reg + 1'b1;
            win_cnt_reg  <= (!bus.enable || win_end)   ? '0 : win_cnt_reg + 1'b1;
            failsafe_reg <= bus.enable && (tmo_hit || (|bus.fan_fail));
        end
    end

    always_comb begin
        curve_raw = 16'(MIN_DUTY);
        if (temp_reg > 8'(TEMP_LO))
            curve_raw = 16'(MIN_DUTY) + 16'(temp_reg - 8'(TEMP_LO)) * 16'(SLOPE);
        curve_duty = sat_duty(curve_raw, PERIOD16);
    end

    generate
        for (genvar gi = 0; gi < N_FAN; gi++) begin : g_ch
            logic [7:0] target;
            logic [7:0] duty_reg;
            logic [7:0] duty_lat_reg;
            logic       pwm_reg;

            always_comb begin
                target = curve_duty;
                if (bus.manual_en)
                    target = sat_duty({8'd0, bus.manual_duty[8*gi +: 8]}, PERIOD16);
            end

            // Applied duty is reloaded at the wrap so each period starting at count 0 is whole
            always_ff @(posedge clk0 or negedge rstn) begin
                if (!rstn) begin
                    duty_reg     <= '0;
                    duty_lat_reg <= '0;
                    pwm_reg      <= 1'b0;
                end else if (!bus.enable) begin
                    duty_reg     <= '0;
                    duty_lat_reg <= '0;
                    pwm_reg      <= 1'b0;
                end else begin
                    if (failsafe_reg)
                        duty_reg <= PERIOD8;
                    else if (ramp_tick) begin
                        case (ramp_dir(duty_reg, target))
                            RAMP_UP:   duty_reg <= duty_reg + 1'b1;
                            RAMP_DOWN: duty_reg <= duty_reg - 1'b1;
                            default:   duty_reg <= duty_reg;
                        endcase
                    end
                    if (pwm_wrap)
                        duty_lat_reg <= duty_reg;
                    pwm_reg <= (pwm_cnt_reg < duty_lat_reg);
                end
            end

            fan_tach_meter #(
                .TACH_DEB  (TACH_DEB),
                .TACH_MIN  (TACH_MIN),
                .FAIL_WINS (FAIL_WINS)
            ) u_tach (
                .clk0       (clk0),
                .rstn       (rstn),
                .enable     (bus.enable),
                .tach_in    (bus.tach_in[gi]),
                .win_end    (win_end),
                .duty_ok    (duty_lat_reg >= 8'(MIN_DUTY)),
                .tach_count (bus.tach_count[16*gi +: 16]),
                .fan_fail   (bus.fan_fail[gi])
            );

            assign bus.duty_cur[8*gi +: 8] = duty_reg;
            assign bus.pwm_out[gi]         = pwm_reg;
        end
    endgenerate
endmodule

// File: tb/tb_fan_ctrl_multi.sv
`timescale 1ns/1ps
// Directed plus randomized bench for fan_ctrl_multi against a behavioural model of the fan rules.
module tb_fan_ctrl_multi;
    localparam int N        = 3;
    localparam int PERIOD   = 222;
    localparam int MIN_DUTY = 60;
    localparam int TEMP_LO  = 40;
    localparam int SLOPE    = 6;
    localparam int TEMP_TMO = 5000;
    localparam int TACH_WIN = 1000;
    localparam int HALF     = 20;

    logic clk0 = 1'b0;
    logic rstn;
    always #5 clk0 = ~clk0;

    fan_ctrl_multi_if #(.N_FAN(N)) bus ();

    fan_ctrl_multi #(
        .N_FAN    (N),
        .RAMP_DIV (4),
        .TEMP_TMO (TEMP_TMO),
        .TACH_WIN (TACH_WIN)
    ) dut (
        .clk0 (clk0),
        .rstn (rstn),
        .bus  (bus)
    );

    // Tach source: every channel toggles every HALF cycles; stuck forces low, glitch pulses ch1
    int         tach_ph [N] = '{default: 0};
    logic [N-1:0] tach_r = '0;
    logic [N-1:0] stuck  = '0;
    logic       glitch_en = 1'b0;
    logic       glitch;

    always @(negedge clk0) begin
        for (int i = 0; i < N; i++) begin
            tach_ph[i] = tach_ph[i] + 1;
            if (tach_ph[i] >= HALF) begin
                tach_ph[i] = 0;
                tach_r[i]  = ~tach_r[i];
            end
        end
    end
    assign glitch      = glitch_en && !tach_r[1] && tach_ph[1] >= 12 && tach_ph[1] < 15;
    assign bus.tach_in = (tach_r & ~stuck) ^ {1'b0, glitch, 1'b0};

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk0);
    endtask

    function automatic int exp_sat(input int d);
        return (d > PERIOD) ? PERIOD : d;
    endfunction

    function automatic int exp_curve(input int t);
        if (t <= TEMP_LO)
            return MIN_DUTY;
        return exp_sat(MIN_DUTY + (t - TEMP_LO) * SLOPE);
    endfunction

    function automatic int duty_of(input int ch);
        return int'(bus.duty_cur[8*ch +: 8]);
    endfunction

    task automatic send_temp(input int t);
        bus.temp_data  = 8'(t);
        bus.temp_valid = 1'b1;
        @(negedge clk0);
        bus.temp_valid = 1'b0;
    endtask

    task automatic measure_high(input int ch, output int hi);
        hi = 0;
        repeat (PERIOD) begin
            @(negedge clk0);
            if (bus.pwm_out[ch]) hi++;
        end
    endtask

    task automatic measure_period(input int ch, output int per);
        logic prev, cur;
        bit   found;
        int   c;
        per   = -1;
        found = 0;
        c     = 0;
        prev  = bus.pwm_out[ch];
        for (int k = 0; k < 3 * PERIOD; k++) begin
            @(negedge clk0);
            cur = bus.pwm_out[ch];
            if (cur && !prev) begin
                if (found) begin
                    per = c;
                    break;
                end
                found = 1;
                c     = 0;
            end
            c++;
            prev = cur;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pwm"}, 32'(bus.pwm_out), 0);
        check({tag, "_duty"}, 32'(bus.duty_cur), 0);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_tach%0d", tag, i), 32'(bus.tach_count[16*i +: 16]), 0);
        check({tag, "_fail"}, 32'(bus.fan_fail), 0);
        check({tag, "_failsafe"}, 32'(bus.failsafe), 0);
    endtask

    initial begin
        int  md [N];
        int  hi, per, d0, t;
        bit  moved;

        bus.enable      = 1'b0;
        bus.temp_valid  = 1'b0;
        bus.temp_data   = '0;
        bus.manual_en   = 1'b0;
        bus.manual_duty = '0;
        rstn            = 1'b1;
        #2 rstn = 1'b0;
        tick(5);
        check_all_zero("reset");
        rstn = 1'b1;
        tick(2);

        // Manual mode: ch0 100, ch1 random, ch2 over range saturates
        md[0] = 100;
        md[1] = $urandom_range(1, PERIOD - 1);
        md[2] = 255;
        for (int i = 0; i < N; i++) bus.manual_duty[8*i +: 8] = 8'(md[i]);
        bus.manual_en = 1'b1;
        bus.enable    = 1'b1;
        glitch_en     = 1'b1;
        tick(1100);
        for (int i = 0; i < N; i++)
            check($sformatf("man_duty_ch%0d", i), 32'(duty_of(i)), 32'(exp_sat(md[i])));
        for (int i = 0; i < N; i++) begin
            measure_high(i, hi);
            check($sformatf("man_high_ch%0d", i), 32'(hi), 32'(exp_sat(md[i])));
        end
        measure_period(0, per);
        check("pwm_period_ch0", 32'(per), 32'(PERIOD));
        tick(400);
        for (int i = 0; i < N; i++)
            check($sformatf("tach_count_ch%0d", i), 32'(bus.tach_count[16*i +: 16]),
                  32'(TACH_WIN / (2 * HALF)));

        // Random manual duties
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                md[i] = $urandom_range(0, 255);
                bus.manual_duty[8*i +: 8] = 8'(md[i]);
            end
            tick(1000);
            for (int i = 0; i < N; i++) begin
                check($sformatf("rnd%0d_duty_ch%0d", k, i), 32'(duty_of(i)), 32'(exp_sat(md[i])));
                measure_high(i, hi);
                check($sformatf("rnd%0d_high_ch%0d", k, i), 32'(hi), 32'(exp_sat(md[i])));
            end
        end

        // Auto curve and ramp rate
        bus.manual_en = 1'b0;
        send_temp(40);
        tick(1000);
        for (int i = 0; i < N; i++)
            check($sformatf("curve40_ch%0d", i), 32'(duty_of(i)), 32'(exp_curve(40)));
        send_temp(50);
        moved = 0;
        for (int k = 0; k < 50 && !moved; k++) begin
            if (duty_of(0) != exp_curve(40)) moved = 1;
            else @(negedge clk0);
        end
        check("ramp_started", 32'(moved), 1);
        d0 = duty_of(0);
        tick(40);
        check("ramp_rate_10steps", 32'(duty_of(0)), 32'(d0 + 10));
        tick(300);
        for (int i = 0; i < N; i++)
            check($sformatf("curve50_ch%0d", i), 32'(duty_of(i)), 32'(exp_curve(50)));

        for (int k = 0; k < 4; k++) begin
            t = $urandom_range(0, 140);
            send_temp(t);
            tick(1000);
            check($sformatf("curve_rnd%0d_t%0d_ch0", k, t), 32'(duty_of(0)), 32'(exp_curve(t)));
            check($sformatf("curve_rnd%0d_t%0d_ch2", k, t), 32'(duty_of(2)), 32'(exp_curve(t)));
        end
        send_temp(100);
        tick(1000);
        check("curve100_sat", 32'(duty_of(0)), 32'(exp_curve(100)));
        measure_high(0, hi);
        check("curve100_const_high", 32'(hi), 32'(PERIOD));

        // Temperature timeout
        send_temp(45);
        tick(TEMP_TMO - 200);
        check("tmo_not_yet", 32'(bus.failsafe), 0);
        tick(300);
        check("tmo_failsafe", 32'(bus.failsafe), 1);
        for (int i = 0; i < N; i++)
            check($sformatf("tmo_duty_ch%0d", i), 32'(duty_of(i)), 32'(PERIOD));
        send_temp(45);
        tick(3);
        check("tmo_cleared", 32'(bus.failsafe), 0);

        // Disable, then stall on ch2 at duty 100
        bus.enable = 1'b0;
        tick(3);
        check("dis_pwm", 32'(bus.pwm_out), 0);
        check("dis_duty", 32'(bus.duty_cur), 0);
        check("dis_failsafe", 32'(bus.failsafe), 0);
        bus.manual_en = 1'b1;
        for (int i = 0; i < N; i++) bus.manual_duty[8*i +: 8] = 8'd100;
        stuck[2]   = 1'b1;
        bus.enable = 1'b1;
        tick(1500);
        check("stall_one_window", 32'(bus.fan_fail), 0);
        tick(600);
        check("stall_fan_fail", 32'(bus.fan_fail), 32'(stuck));
        tick(3);
        check("stall_failsafe", 32'(bus.failsafe), 1);
        for (int i = 0; i < N; i++)
            check($sformatf("stall_duty_ch%0d", i), 32'(duty_of(i)), 32'(PERIOD));

        bus.enable = 1'b0;
        tick(3);
        check("off_fail", 32'(bus.fan_fail), 0);
        check("off_failsafe", 32'(bus.failsafe), 0);
        check("off_duty", 32'(bus.duty_cur), 0);
        measure_high(0, hi);
        check("off_pwm_low", 32'(hi), 0);

        // Asynchronous reset mid-window
        stuck      = '0;
        bus.enable = 1'b1;
        tick(1500);
        check("pre_rst_tach_ch0", 32'(bus.tach_count[15:0]), 32'(TACH_WIN / (2 * HALF)));
        rstn = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick(3);
        rstn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
